// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
//
// Contents:
//   MULDIV_ITERATIONS  number of shift-add / shift-subtract steps per operation
//   COUNT_W            width of the iteration counter
//   muldiv_op_t        operation encoding as presented on the op port
//   muldiv_state_t     sequencer state encoding
//   is_signed_op       true for MULT / DIV
//   is_div_op          true for DIV / DIVU
//   magnitude          absolute value for signed ops, raw value otherwise
package muldiv_pkg;

    localparam int MULDIV_ITERATIONS = 32;
    localparam int COUNT_W           = $clog2(MULDIV_ITERATIONS);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

    function automatic logic is_signed_op(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // 32'h80000000 maps onto itself, which is exactly the unsigned magnitude 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signed_op);
        return (signed_op && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential multiply/divide datapath (purely combinational).
//
// Ports:
//   is_div    1 = restoring shift-subtract divide step, 0 = shift-add multiply step
//   acc       64-bit accumulator
//                multiply: {partial product high, remaining multiplier bits}
//                divide:   {partial remainder, dividend bits / quotient bits}
//   operand   multiplicand (multiply) or divisor (divide), already a magnitude
//   acc_next  accumulator after this step
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] partial;
    logic [32:0] sum;
    logic [32:0] rem_shift;
    logic [31:0] diff;

    // The divide difference is only kept when rem_shift >= operand, in which
    // case it is always smaller than operand and fits in 32 bits.
    always_comb begin
        partial   = acc[0] ? {1'b0, operand} : 33'd0;
        sum       = {1'b0, acc[63:32]} + partial;
        rem_shift = {acc[63:32], acc[31]};
        diff      = rem_shift[31:0] - operand;

        if (is_div) begin
            if (rem_shift >= {1'b0, operand}) begin
                acc_next = {diff, acc[30:0], 1'b1};
            end else begin
                acc_next = {rem_shift[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Iterative MIPS-style HI/LO multiply/divide unit for the EX stage.
// Operands are reduced to magnitudes, 32 steps are run through muldiv_step,
// signs are fixed up, and the result lands in HI/LO.
//
// Optional build macro: MULDIV_DEBUG_EN adds debug_muldivState,
// debug_muldivCount and debug_muldivAcc outputs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op           request an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   operandA, operandB  rs / rt values, sampled with start
//   flush               abandon any in-flight operation
//   writeHi, writeLo,
//   writeData           MTHI / MTLO, honoured only while idle
//   hi, lo              architectural HI / LO
//   busy                sequencer not idle
//   stallRequest        combinational hold request to IF/ID/EX
//   done                one-cycle registered pulse after a result is written
module ex_muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    input  logic        writeHi,
    input  logic        writeLo,
    input  logic [31:0] writeData,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stallRequest,
    output logic        done
`ifdef MULDIV_DEBUG_EN
    ,
    output logic [1:0]  debug_muldivState,
    output logic [4:0]  debug_muldivCount,
    output logic [63:0] debug_muldivAcc
`endif
);

    muldiv_state_t      state;
    muldiv_state_t      state_next;
    logic [COUNT_W-1:0] count;
    muldiv_op_t         op_reg;
    muldiv_op_t         op_in;
    logic               sign_a;
    logic               sign_b;
    logic [31:0]        operand_a_raw;
    logic [31:0]        operand_b;
    logic [63:0]        acc;
    logic [63:0]        acc_step;
    logic               op_signed;
    logic               op_div;
    logic               start_signed;
    logic [31:0]        result_hi;
    logic [31:0]        result_lo;

    assign op_in        = muldiv_op_t'(op);
    assign start_signed = is_signed_op(op_in);
    assign op_signed    = is_signed_op(op_reg);
    assign op_div       = is_div_op(op_reg);
    assign busy         = (state != ST_IDLE);

    muldiv_step u_step (
        .is_div   (op_div),
        .acc      (acc),
        .operand  (operand_b),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every transition, including a start seen in IDLE.
    always_comb begin
        state_next   = state;
        stallRequest = 1'b0;
        case (state)
            ST_IDLE: begin
                stallRequest = start;
                if (start) begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                stallRequest = 1'b1;
                if (count == '0) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                stallRequest = 1'b1;
                state_next   = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    // Sign fixup of the magnitude result. Divide-by-zero bypasses the fixup
    // and reports the raw dividend in HI with an all-ones quotient.
    always_comb begin
        result_hi = acc[63:32];
        result_lo = acc[31:0];
        if (op_div) begin
            if (operand_b == 32'd0) begin
                result_hi = operand_a_raw;
                result_lo = 32'hFFFF_FFFF;
            end else begin
                if (op_signed && (sign_a ^ sign_b)) begin
                    result_lo = 32'd0 - acc[31:0];
                end
                if (op_signed && sign_a) begin
                    result_hi = 32'd0 - acc[63:32];
                end
            end
        end else if (op_signed && (sign_a ^ sign_b)) begin
            {result_hi, result_lo} = 64'd0 - acc;
        end
    end

    // Operand capture, iteration and HI/LO update. MTHI/MTLO are only taken
    // in IDLE; a write and a start in the same cycle both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            op_reg        <= OP_MULT;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            operand_a_raw <= 32'd0;
            operand_b     <= 32'd0;
            acc           <= 64'd0;
            hi            <= 32'd0;
            lo            <= 32'd0;
            done          <= 1'b0;
        end else begin
            done <= (state == ST_DONE) && !flush;
            case (state)
                ST_IDLE: begin
                    if (writeHi) begin
                        hi <= writeData;
                    end
                    if (writeLo) begin
                        lo <= writeData;
                    end
                    if (start && !flush) begin
                        op_reg        <= op_in;
                        sign_a        <= operandA[31];
                        sign_b        <= operandB[31];
                        operand_a_raw <= operandA;
                        operand_b     <= magnitude(operandB, start_signed);
                        acc           <= {32'd0, magnitude(operandA, start_signed)};
                        count         <= COUNT_W'(MULDIV_ITERATIONS - 1);
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        acc <= acc_step;
                        if (count != '0) begin
                            count <= count - COUNT_W'(1);
                        end
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        hi <= result_hi;
                        lo <= result_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULDIV_DEBUG_EN
    assign debug_muldivState = state;
    assign debug_muldivCount = count;
    assign debug_muldivAcc   = acc;
`endif

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed scenarios plus a
// randomized sweep compared against a 64-bit arithmetic reference model.
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic        flush = 1'b0;
    logic        writeHi = 1'b0;
    logic        writeLo = 1'b0;
    logic [31:0] writeData = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stallRequest;
    logic        done;

    int checks = 0;
    int failures = 0;

    ex_muldiv_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .operandA     (operandA),
        .operandB     (operandB),
        .flush        (flush),
        .writeHi      (writeHi),
        .writeLo      (writeLo),
        .writeData    (writeData),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .stallRequest (stallRequest),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        res = 64'd0;
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    if (o == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = ua / ub;
                        r = ua % ub;
                    end
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        v = 32'd0;
        case ($urandom_range(0, 4))
            0: v = $urandom();
            1: v = $urandom_range(0, 40);
            2: v = 32'd0 - $urandom_range(1, 40);
            3: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h8000_0000;
                    1: v = 32'hFFFF_FFFF;
                    2: v = 32'h7FFF_FFFF;
                    default: v = 32'd1;
                endcase
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Issues one operation starting from just after a clock edge and watches
    // the 40 edges that follow it; done_edge is relative to the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_edge, output int stall_cycles,
                          output int done_pulses, output logic busy_at_done);
        done_edge = -1;
        stall_cycles = 0;
        done_pulses = 0;
        busy_at_done = 1'b1;
        op = o;
        operandA = a;
        operandB = b;
        start = 1'b1;
        #1;
        if (stallRequest) stall_cycles++;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (stallRequest) stall_cycles++;
            if (done) begin
                done_pulses++;
                if (done_edge < 0) begin
                    done_edge = k;
                    busy_at_done = busy;
                end
            end
        end
    endtask

    // Watches the next 45 edges for done; first_edge counts from the call.
    task automatic wait_done(output int first_edge, output int pulses);
        first_edge = -1;
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first_edge < 0) first_edge = k;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected %h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected %h", lo, 32'd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (stallRequest !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", stallRequest); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_multu_latency();
        int de; int sc; int dp; logic bd;
        run_op(2'b01, 32'd7, 32'd6, de, sc, dp, bd);
        checks++; if (de !== 34) begin failures++; $display("[TB] FAIL multu_done_edge: got %0d expected 34", de); end
        checks++; if (sc !== 34) begin failures++; $display("[TB] FAIL multu_stall_cycles: got %0d expected 34", sc); end
        checks++; if (dp !== 1) begin failures++; $display("[TB] FAIL multu_done_pulses: got %0d expected 1", dp); end
        checks++; if (bd !== 1'b0) begin failures++; $display("[TB] FAIL multu_busy_at_done: got %b expected 0", bd); end
        checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL multu_hi: got %h expected %h", hi, 32'd0); end
        checks++; if (lo !== 32'd42) begin failures++; $display("[TB] FAIL multu_lo: got %h expected %h", lo, 32'd42); end
    endtask

    task automatic test_mult_signed();
        int de; int sc; int dp; logic bd;
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, de, sc, dp, bd);
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_neg_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL mult_neg_lo: got %h expected %h", lo, 32'hFFFF_FFFE); end
    endtask

    task automatic test_divide();
        int de; int sc; int dp; logic bd;
        run_op(2'b11, 32'd100, 32'd7, de, sc, dp, bd);
        checks++; if (lo !== 32'd14) begin failures++; $display("[TB] FAIL divu_lo: got %h expected %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin failures++; $display("[TB] FAIL divu_hi: got %h expected %h", hi, 32'd2); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, de, sc, dp, bd);
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_neg_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_neg_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, de, sc, dp, bd);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("[TB] FAIL div_ovf_lo: got %h expected %h", lo, 32'h8000_0000); end
        checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL div_ovf_hi: got %h expected %h", hi, 32'd0); end
    endtask

    task automatic test_div_zero();
        int de; int sc; int dp; logic bd;
        run_op(2'b11, 32'd5, 32'd0, de, sc, dp, bd);
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divu_zero_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
        checks++; if (hi !== 32'd5) begin failures++; $display("[TB] FAIL divu_zero_hi: got %h expected %h", hi, 32'd5); end
        checks++; if (dp !== 1) begin failures++; $display("[TB] FAIL divu_zero_pulses: got %0d expected 1", dp); end
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, de, sc, dp, bd);
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_zero_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin failures++; $display("[TB] FAIL div_zero_hi: got %h expected %h", hi, 32'hFFFF_FFFB); end
    endtask

    task automatic test_flush_and_write();
        int fe; int fp;
        writeHi = 1'b1;
        writeLo = 1'b1;
        writeData = 32'h1234;
        @(posedge clk);
        #1;
        writeHi = 1'b0;
        writeLo = 1'b0;
        checks++; if ({hi, lo} !== {32'h1234, 32'h1234}) begin failures++; $display("[TB] FAIL mt_write: got %h_%h expected 1234_1234", hi, lo); end

        op = 2'b00; operandA = 32'd3; operandB = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
        checks++; if ({hi, lo} !== {32'h1234, 32'h1234}) begin failures++; $display("[TB] FAIL flush_hilo: got %h_%h expected 1234_1234", hi, lo); end
        wait_done(fe, fp);
        checks++; if (fp !== 0) begin failures++; $display("[TB] FAIL flush_no_done: got %0d pulses expected 0", fp); end
        checks++; if ({hi, lo} !== {32'h1234, 32'h1234}) begin failures++; $display("[TB] FAIL flush_hilo_later: got %h_%h expected 1234_1234", hi, lo); end

        // MULTU 2 x 3 with a dropped MTLO and an ignored start while busy.
        op = 2'b01; operandA = 32'd2; operandB = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        writeLo = 1'b1;
        writeData = 32'hDEAD;
        op = 2'b11; operandA = 32'd1; operandB = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        writeLo = 1'b0;
        start = 1'b0;
        checks++; if (lo !== 32'h1234) begin failures++; $display("[TB] FAIL busy_writelo: got %h expected %h", lo, 32'h1234); end
        wait_done(fe, fp);
        checks++; if (fp !== 1) begin failures++; $display("[TB] FAIL busy_op_pulses: got %0d expected 1", fp); end
        checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin failures++; $display("[TB] FAIL busy_op_result: got %h_%h expected 00000000_00000006", hi, lo); end
    endtask

    task automatic test_write_with_start();
        int fe; int fp;
        writeHi = 1'b1;
        writeData = 32'hABCD;
        op = 2'b01; operandA = 32'd5; operandB = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        writeHi = 1'b0;
        start = 1'b0;
        checks++; if (hi !== 32'hABCD) begin failures++; $display("[TB] FAIL write_start_hi: got %h expected %h", hi, 32'hABCD); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL write_start_busy: got %b expected 1", busy); end
        wait_done(fe, fp);
        checks++; if (fe !== 34) begin failures++; $display("[TB] FAIL write_start_latency: got %0d expected 34", fe); end
        checks++; if ({hi, lo} !== {32'd0, 32'd25}) begin failures++; $display("[TB] FAIL write_start_result: got %h_%h expected 00000000_00000019", hi, lo); end
    endtask

    task automatic test_async_reset();
        int de; int sc; int dp; logic bd;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, de, sc, dp, bd);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("[TB] FAIL pre_reset_result: got %h_%h expected fffffffe_00000001", hi, lo); end
        op = 2'b00; operandA = 32'd9; operandB = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("[TB] FAIL async_reset_hilo: got %h_%h expected 0", hi, lo); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy, done); end
        run_op(2'b11, 32'd100, 32'd7, de, sc, dp, bd);
        checks++; if (de !== 34 || dp !== 1) begin failures++; $display("[TB] FAIL post_reset_timing: got edge=%0d pulses=%0d expected 34 1", de, dp); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("[TB] FAIL post_reset_result: got %h_%h expected 00000002_0000000e", hi, lo); end
    endtask

    task automatic test_random();
        int de; int sc; int dp; logic bd;
        logic [1:0] o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expected;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            expected = ref_model(o, a, b);
            run_op(o, a, b, de, sc, dp, bd);
            checks++;
            if ({hi, lo} !== expected || de !== 34 || dp !== 1) begin
                failures++;
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got %h_%h edge=%0d pulses=%0d expected %h edge=34 pulses=1",
                         i, o, a, b, hi, lo, de, dp, expected);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_multu_latency();
        test_mult_signed();
        test_divide();
        test_div_zero();
        test_flush_and_write();
        test_write_with_start();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sequencer.md
EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-002 SHALL have port start, input, 1 bit: request a new operation, sampled on the rising edge of clk.
REQ-003 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-004 SHALL have ports operandA and operandB, input, 32 bits each: registerRs value and registerRt value, sampled with start.
REQ-005 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-006 SHALL have ports writeHi and writeLo, input, 1 bit each, plus writeData, input, 32 bits: MTHI/MTLO.
REQ-007 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port stallRequest, output, 1 bit: combinational pipeline hold request to IF/ID/EX.
REQ-010 SHALL have port done, output, 1 bit: one-cycle registered pulse when a result is written to hi/lo.

Function
REQ-011 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-012 SHALL, in IDLE with start=1, latch op, |operandA| and |operandB| (signed ops) or the raw values (unsigned ops), plus both sign bits, and enter CALC with iteration counter = 31.
REQ-013 SHALL, in CALC, perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, decrement the counter, and go to FIX after the step with counter = 0 (32 steps).
REQ-014 SHALL, in FIX, negate the results for signed ops: product if the operand signs differ; quotient if the signs differ; remainder if the dividend is negative. It SHALL write the 64-bit product to {hi,lo}, or remainder to hi and quotient to lo, then enter DONE.
REQ-015 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-016 SHALL set latency so that start sampled at edge N gives done=1 and valid hi/lo in the cycle after edge N+34.
REQ-017 SHALL drive stallRequest = (IDLE and start) or CALC or FIX, deasserting in DONE.
REQ-018 SHALL ignore start while not in IDLE.
REQ-019 SHALL, on divide by zero, yield lo=32'hFFFFFFFF and hi=operandA (raw) for both DIV and DIVU, with no sign fixup.
REQ-020 SHALL, on flush in any state, go to IDLE at the next edge with hi/lo unchanged and no done pulse; flush SHALL win over a simultaneous start.
REQ-021 SHALL apply writeHi/writeLo only in IDLE; in other states they SHALL be dropped, because the pipeline is stalled.
REQ-022 SHALL let an operation's result overwrite a writeHi/writeLo in DONE->IDLE ordering; when writeHi and start occur in the same IDLE cycle, SHALL apply the write and start the operation.
REQ-023 SHALL produce the DIV 32'h80000000 / 32'hFFFFFFFF result from the magnitude algorithm: lo=32'h80000000, hi=0.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, counter=0, hi=0, lo=0, done=0 and all internal operand/accumulator registers to 0, regardless of clk.
REQ-025 SHALL abandon an in-flight operation when reset asserts mid-operation; after release busy=0, with no done pulse.

Configuration
REQ-026 SHALL, with macro MULDIV_DEBUG_EN defined, add outputs debug_muldivState (2 bits), debug_muldivCount (5 bits) and debug_muldivAcc (64 bits); without it, those ports and their logic SHALL be absent and function SHALL be identical.

Structure
REQ-027 SHALL place the op encodings, the state encodings and the constant MULDIV_ITERATIONS=32 in shared package muldiv_pkg.
REQ-028 SHALL implement the per-cycle add/subtract-and-shift in one combinational sub-module muldiv_step, instantiated once; the sequencer owns all registers.

Verification
REQ-029 Bench SHALL cover: MULTU 7 x 6 at edge N -> done after edge N+34, hi=0, lo=42, stallRequest high cycles N..N+33.
REQ-030 Bench SHALL cover: MULT 32'hFFFFFFFF x 2 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
REQ-031 Bench SHALL cover: DIVU 100 / 7 -> lo=14, hi=2; DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-032 Bench SHALL cover: DIVU 5 / 0 -> lo=32'hFFFFFFFF, hi=5, done pulses once.
REQ-033 Bench SHALL cover: hi=lo=32'h1234, then start MULT 3 x 3 and flush 10 cycles later -> IDLE next edge, hi=lo=32'h1234, no done; writeLo while busy -> lo unchanged.
REQ-034 Bench SHALL cover: rst_n low mid-CALC, asynchronously -> busy=0, hi=lo=0 immediately; a new start after release completes normally.
